// File: rtl/ifm_window_fetch_if.sv
// ifm_window_fetch_if
// Groups the control, IFM read-port and pixel-stream signals of
// ifm_window_fetch.
//   master : the window fetch sequencer
//   slave  : the environment (controller, IFM memory array, conv unit)
// Control:  start, busy, done
// Memory:   ifm_enable_read_{A,B}_next, ifm_address_read_{A,B}_next, data_in_{A,B}
// Stream:   pix_out_{A,B}, pix_valid, pix_b_valid, pix_ready, window_last, map_last
interface ifm_window_fetch_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_SIZE_IFM = 10
);
  logic                        start;
  logic                        busy;
  logic                        done;
  logic                        ifm_enable_read_A_next;
  logic                        ifm_enable_read_B_next;
  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_A_next;
  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_B_next;
  logic [DATA_WIDTH-1:0]       data_in_A;
  logic [DATA_WIDTH-1:0]       data_in_B;
  logic [DATA_WIDTH-1:0]       pix_out_A;
  logic [DATA_WIDTH-1:0]       pix_out_B;
  logic                        pix_valid;
  logic                        pix_b_valid;
  logic                        pix_ready;
  logic                        window_last;
  logic                        map_last;

  modport master (
    input  start, data_in_A, data_in_B, pix_ready,
    output busy, done,
           ifm_enable_read_A_next, ifm_enable_read_B_next,
           ifm_address_read_A_next, ifm_address_read_B_next,
           pix_out_A, pix_out_B, pix_valid, pix_b_valid,
           window_last, map_last
  );

  modport slave (
    output start, data_in_A, data_in_B, pix_ready,
    input  busy, done,
           ifm_enable_read_A_next, ifm_enable_read_B_next,
           ifm_address_read_A_next, ifm_address_read_B_next,
           pix_out_A, pix_out_B, pix_valid, pix_b_valid,
           window_last, map_last
  );
endinterface

// File: rtl/ifm_window_fetch.sv
// ifm_window_fetch
// Sweeps a stride-1 KxK window over one IFM plane and streams the window
// pixels two per cycle (even element on lane A, odd element on lane B).
// Reads go out on both memory ports; the 1-cycle read latency is absorbed by
// a 2-entry first-word-fall-through skid FIFO driven by a credit check, so
// backpressure on pix_ready never drops or repeats a pair.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : ifm_window_fetch_if.master (control, memory read ports, stream)
// Build option:
//   WINDOW_FETCH_ZERO_PAD_EN : 1-pixel zero padding (OFM = IFM_SIZE);
//   out-of-bounds lanes keep their read enable low and deliver zero.
//
// state | meaning
// IDLE  | counters cleared, waiting for start
// FETCH | issuing one read pair per cycle while credit allows
// DRAIN | all pairs issued, waiting for FIFO empty and nothing in flight
// DONE  | one-cycle done pulse
module ifm_window_fetch #(
  parameter int DATA_WIDTH       = 32,
  parameter int IFM_SIZE         = 32,
  parameter int KERNEL_SIZE      = 3,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE*IFM_SIZE)
) (
  input logic                clk,
  input logic                reset,
  ifm_window_fetch_if.master bus
);

`ifdef WINDOW_FETCH_ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  localparam int OFM   = IFM_SIZE - KERNEL_SIZE + 1 + 2*PAD;
  localparam int K2    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int PAIRS = (K2 + 1) / 2;
  localparam int CW    = $clog2(IFM_SIZE + KERNEL_SIZE + 1);
  localparam int PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int AW    = ADDRESS_SIZE_IFM;

  localparam logic [CW-1:0] K_LAST    = CW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] O_LAST    = CW'(OFM - 1);
  localparam logic [PW-1:0] P_LAST    = PW'(PAIRS - 1);
  localparam logic [AW-1:0] IFM_A     = AW'(IFM_SIZE);
  localparam logic          LAST_HALF = ((K2 % 2) == 1);
`ifdef WINDOW_FETCH_ZERO_PAD_EN
  localparam logic [CW-1:0] IFM_C     = CW'(IFM_SIZE);
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  bv;
    logic                  wl;
    logic                  ml;
  } entry_t;

  logic [1:0]    state_q;
  logic [CW-1:0] row_q, col_q, kr_q, kc_q;
  logic [PW-1:0] pair_q;
  logic          inflight_q, en_a_q, en_b_q, bv_q, wl_q, ml_q;
  entry_t        ent0_q, ent1_q, new_ent;
  logic [1:0]    count_q;

  logic [CW-1:0] kr_b, kc_b, kr_n, kc_n;
  logic          win_last, b_real, map_last_c, pop, push, issue;
  logic [2:0]    occ;
  logic [AW:0]   elem_a, elem_b;
  logic          en_a, en_b;

  // {in_bounds, address} of element (r+kr, c+kc), shifted by the pad offset
  function automatic logic [AW:0] elem(input logic [CW-1:0] r, input logic [CW-1:0] kr,
                                       input logic [CW-1:0] c, input logic [CW-1:0] kc);
    logic [CW-1:0] ys, xs;
    logic          inb;
    ys = r + kr;
    xs = c + kc;
`ifdef WINDOW_FETCH_ZERO_PAD_EN
    inb = (ys != '0) && (ys <= IFM_C) && (xs != '0) && (xs <= IFM_C);
    ys  = ys - 1'b1;
    xs  = xs - 1'b1;
`else
    inb = 1'b1;
`endif
    return {inb, AW'(ys) * IFM_A + AW'(xs)};
  endfunction

  always_comb begin
    // lane B element follows lane A in row-major order; next pair follows B
    kr_b = kr_q;
    kc_b = kc_q + 1'b1;
    if (kc_q == K_LAST) begin
      kr_b = kr_q + 1'b1;
      kc_b = '0;
    end
    kr_n = kr_b;
    kc_n = kc_b + 1'b1;
    if (kc_b == K_LAST) begin
      kr_n = kr_b + 1'b1;
      kc_n = '0;
    end
  end

  assign win_last   = (pair_q == P_LAST);
  assign b_real     = !(LAST_HALF && win_last);
  assign map_last_c = win_last && (row_q == O_LAST) && (col_q == O_LAST);

  assign pop   = (count_q != 2'd0) && bus.pix_ready;
  assign push  = inflight_q;
  assign occ   = {1'b0, count_q} + {2'b0, inflight_q};
  // issue only if the returning pair is guaranteed a FIFO slot
  assign issue = (state_q == S_FETCH) && ((occ - {2'b0, pop}) < 3'd2);

  assign elem_a = elem(row_q, kr_q, col_q, kc_q);
  assign elem_b = elem(row_q, kr_b, col_q, kc_b);
  assign en_a   = issue && elem_a[AW];
  assign en_b   = issue && b_real && elem_b[AW];

  // disabled ports present address 0 so the memory can OR the two ports
  assign bus.ifm_enable_read_A_next  = en_a;
  assign bus.ifm_enable_read_B_next  = en_b;
  assign bus.ifm_address_read_A_next = en_a ? elem_a[AW-1:0] : '0;
  assign bus.ifm_address_read_B_next = en_b ? elem_b[AW-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      kr_q    <= '0;
      kc_q    <= '0;
      pair_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          row_q  <= '0;
          col_q  <= '0;
          kr_q   <= '0;
          kc_q   <= '0;
          pair_q <= '0;
          if (bus.start) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (issue) begin
            if (map_last_c) state_q <= S_DRAIN;
            if (win_last) begin
              pair_q <= '0;
              kr_q   <= '0;
              kc_q   <= '0;
              if (col_q == O_LAST) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
              end else begin
                col_q <= col_q + 1'b1;
              end
            end else begin
              pair_q <= pair_q + 1'b1;
              kr_q   <= kr_n;
              kc_q   <= kc_n;
            end
          end
        end
        S_DRAIN: begin
          if (!inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop)))
            state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // sideband travels with the request and meets its data one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q <= 1'b0;
      en_a_q     <= 1'b0;
      en_b_q     <= 1'b0;
      bv_q       <= 1'b0;
      wl_q       <= 1'b0;
      ml_q       <= 1'b0;
    end else begin
      inflight_q <= issue;
      en_a_q     <= en_a;
      en_b_q     <= en_b;
      bv_q       <= b_real;
      wl_q       <= win_last;
      ml_q       <= map_last_c;
    end
  end

  // lanes that were not read (padding, odd tail) capture zero
  always_comb begin
    new_ent    = '0;
    new_ent.a  = en_a_q ? bus.data_in_A : '0;
    new_ent.b  = en_b_q ? bus.data_in_B : '0;
    new_ent.bv = bv_q;
    new_ent.wl = wl_q;
    new_ent.ml = ml_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) ent0_q <= new_ent;
          else                 ent1_q <= new_ent;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          ent0_q  <= ent1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            ent0_q <= new_ent;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= new_ent;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pix_valid   = (count_q != 2'd0);
  assign bus.pix_out_A   = ent0_q.a;
  assign bus.pix_out_B   = ent0_q.b;
  assign bus.pix_b_valid = bus.pix_valid && ent0_q.bv;
  assign bus.window_last = bus.pix_valid && ent0_q.wl;
  assign bus.map_last    = bus.pix_valid && ent0_q.ml;
  assign bus.busy        = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign bus.done        = (state_q == S_DONE);

endmodule

// File: doc/ifm_window_fetch.md
# ifm_window_fetch

Read-side sequencer for the IFM memory array: sweeps a stride-1 K×K convolution window across one IFM plane and streams the window pixels to the downstream convolution unit two per cycle. It drives the `*_next` read enables and addresses of the memory array, using both true-dual-port ports A and B. It absorbs the memory's 1-cycle read latency behind a 2-entry skid FIFO so that downstream backpressure never loses data.

## Interface
- `DATA_WIDTH`, 32, pixel width.
- `IFM_SIZE`, 32, IFM plane edge length.
- `KERNEL_SIZE`, 3, window edge length (odd, ≥1, ≤ IFM_SIZE).
- `ADDRESS_SIZE_IFM`, $clog2(IFM_SIZE*IFM_SIZE), memory address width.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: begin one plane sweep; sampled only in IDLE.
- `busy` out 1: high from the first FETCH cycle until `done`.
- `done` out 1: one-cycle pulse after the last pair is accepted.
- `ifm_enable_read_A_next` out 1: port-A read enable.
- `ifm_enable_read_B_next` out 1: port-B read enable.
- `ifm_address_read_A_next` out ADDRESS_SIZE_IFM: port-A address.
- `ifm_address_read_B_next` out ADDRESS_SIZE_IFM: port-B address.
- `data_in_A` in DATA_WIDTH: port-A read data, valid 1 cycle after its enable.
- `data_in_B` in DATA_WIDTH: port-B read data, valid 1 cycle after its enable.
- `pix_out_A` out DATA_WIDTH: even-index window element.
- `pix_out_B` out DATA_WIDTH: odd-index window element.
- `pix_valid` out 1: FIFO head is valid.
- `pix_b_valid` out 1: `pix_out_B` carries a real element. Low on the final pair of an odd-size window.
- `pix_ready` in 1: downstream accepts the head when `pix_valid & pix_ready`.
- `window_last` out 1: head is the last pair of its window.
- `map_last` out 1: head is the last pair of the plane.

## Operation
- OFM = IFM_SIZE−KERNEL_SIZE+1. PAIRS = ceil(K²/2). Sweep order:
  - output row r, then output column c;
  - within each window, element index e = kr·K+kc in row-major order.
- Element address = (r+kr)·IFM_SIZE + (c+kc). Element e goes to port A if e is even, port B if e is odd.
- The final pair of an odd K² window drives only port A. `ifm_enable_read_B_next`=0, B address=0, `pix_b_valid`=0.
- Disabled ports drive address 0, so OR-combining addresses in the memory array stays correct.
- FSM states:
  - IDLE: `start` → FETCH. Counters are cleared.
  - FETCH: issue one pair per cycle while credits allow. After the last pair is issued → DRAIN.
  - DRAIN: wait until the FIFO is empty and nothing is in flight → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Credit rule: issue when fifo_count + inflight − pop < 2, where pop = `pix_valid & pix_ready`.
- On issue, the sideband (`pix_b_valid`, `window_last`, `map_last`) is registered alongside the request. It is pushed into the FIFO with the returning data on the next cycle.
- The FIFO is 2 deep and first-word-fall-through. Outputs are driven from the head register.
- `start` outside IDLE is ignored.
- Asynchronous reset at any time:
  - state returns to IDLE;
  - FIFO and the in-flight flag are flushed;
  - returning data is discarded.
- Output values while `reset` is asserted:
  - all enables, addresses, `pix_*`, `window_last`, `map_last`, `busy` and `done` are 0.

## Timing
- Cycle 0: `start` is high in IDLE.
- Cycle 1: FETCH, first read issued, `busy`=1.
- Cycle 2: data returns.
- Cycle 3: first `pix_valid`=1.
- With `pix_ready` held high, throughput is one pair per cycle with no bubbles.
- Total issue cycles = OFM²·PAIRS.
- When `pix_ready` drops, at most 2 pairs are buffered and issue stalls on the same cycle. No data loss and no duplicate.
- `done` rises the cycle after the `map_last` pair is accepted. `busy` falls in that same cycle.

## Configuration
- `WINDOW_FETCH_ZERO_PAD_EN` defined:
  - 1-pixel zero padding, so OFM = IFM_SIZE;
  - element coordinate = (r+kr−1, c+kc−1);
  - for an out-of-bounds coordinate, that port's enable=0 and address=0, and the FIFO captures 0 instead of memory data for that lane.
- Not defined:
  - no padding; OFM = IFM_SIZE−K+1;
  - no bounds logic.

## Test plan
- IFM_SIZE=4, K=3, `pix_ready`=1, start pulse:
  - 20 pairs total (4 windows of 5 pairs each);
  - window 0 addresses are A/B (0,1)(2,4)(5,6)(8,9)(10,–);
  - window 1 addresses are (1,2)(3,5)(6,7)(9,10)(11,–);
  - `window_last` on pairs 5, 10, 15, 20; `map_last` on pair 20;
  - first `pix_valid` in cycle 3; `done` in cycle 23.
- Same configuration with `pix_ready` toggling 1,0,0,1 repeatedly:
  - the output pair sequence is identical to the previous run;
  - fifo_count never exceeds 2.
- Memory model returns data = address:
  - `pix_out_A`/`pix_out_B` equal the addresses above;
  - `pix_b_valid`=0 on every 5th pair.
- `reset` asserted mid-sweep after pair 7:
  - all outputs go to 0 immediately;
  - the next `start` restarts at window 0, address 0.
- `start` pulsed during FETCH: ignored; the pair count stays 20.
- With `WINDOW_FETCH_ZERO_PAD_EN`, IFM_SIZE=4, K=3:
  - 16 windows, 80 pairs;
  - window 0 is (0,0)(0,0)(0,1)(0,4)(5,–) with memory enables low on the padded lanes.
